// File: rtl/cnn_pe_top_if.sv
// Bus bundle for the CNN processing element: activation/state stream in,
// weight side-port, weight read address, and the tagged result out.
interface cnn_pe_top_if #(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int ADDR_B   = 4,
  parameter int OUT_W    = 21
);
  logic [1:0]                  pe_in_state;
  logic [ICP_NUM*DATA_WID-1:0] pe_in_a;
  logic [DATA_WID-1:0]         wrb_data;
  logic [ADDR_B-1:0]           wrb_addr;
  logic [ICP_NUM-1:0]          wrb;
  logic [ADDR_B-1:0]           rdb_addr;
  logic [1:0]                  pe_out_state;
  logic [OUT_W-1:0]            pe_out_data;

  modport master (
    output pe_in_state, pe_in_a, wrb_data, wrb_addr, wrb, rdb_addr,
    input  pe_out_state, pe_out_data
  );

  modport slave (
    input  pe_in_state, pe_in_a, wrb_data, wrb_addr, wrb, rdb_addr,
    output pe_out_state, pe_out_data
  );
endinterface

// File: rtl/cnn_pe_top.sv
// CNN processing element: per-lane weight buffers, two-stage multiply/lane-sum
// accumulate, one-cycle CNN_FIN result tag. Define PE_ACC_SAT_EN to saturate.
module cnn_pe_top #(
  parameter int DATA_WID  = 8,
  parameter int ICP_NUM   = 4,
  parameter int AUG_FCT_B = 3,
  parameter int ADDR_B    = 4,
  parameter int CAP_B     = 9
) (
  input  logic          clk,
  input  logic          reset,
  cnn_pe_top_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_WID;
  localparam int OUT_W  = PROD_W + $clog2(ICP_NUM) + AUG_FCT_B;
  localparam int IDX_W  = $clog2(CAP_B);

  localparam logic [1:0] ST_INVALID = 2'd0;
  localparam logic [1:0] ST_VALID   = 2'd1;
  localparam logic [1:0] ST_FIN     = 2'd2;

  localparam logic [ADDR_B:0] CAP_LIM = (ADDR_B+1)'(CAP_B);

  logic [DATA_WID-1:0] wbuf_r [ICP_NUM][CAP_B];
  logic [DATA_WID-1:0] rd_w_s [ICP_NUM];
  logic [PROD_W-1:0]   prod_r [ICP_NUM];
  logic [1:0]          in_tag_s;
  logic [1:0]          tag_r;
  logic                rd_ok_s;
  logic                wr_ok_s;
  logic [OUT_W-1:0]    lane_sum_s;
  logic [OUT_W-1:0]    acc_sum_s;
  logic [OUT_W-1:0]    acc_r;
  logic [1:0]          out_state_r;
  logic [OUT_W-1:0]    out_data_r;

  function automatic logic [OUT_W-1:0] acc_add(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b);
    logic [OUT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef PE_ACC_SAT_EN
    if (s[OUT_W]) begin
      acc_add = {OUT_W{1'b1}};
    end else begin
      acc_add = s[OUT_W-1:0];
    end
`else
    acc_add = s[OUT_W-1:0];
`endif
  endfunction

  // Address range qualification for the weight side-port and read port
  always_comb begin
    rd_ok_s = ({1'b0, bus.rdb_addr} < CAP_LIM);
    wr_ok_s = ({1'b0, bus.wrb_addr} < CAP_LIM);
  end

  // Weight storage; out-of-range addresses never write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ICP_NUM; i++) begin
        for (int j = 0; j < CAP_B; j++) begin
          wbuf_r[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ICP_NUM; i++) begin
        if (bus.wrb[i] && wr_ok_s) begin
          wbuf_r[i][bus.wrb_addr[IDX_W-1:0]] <= bus.wrb_data;
        end
      end
    end
  end

  // Combinational weight read (sees pre-write contents, 0 beyond depth)
  always_comb begin
    for (int i = 0; i < ICP_NUM; i++) begin
      if (rd_ok_s) begin
        rd_w_s[i] = wbuf_r[i][bus.rdb_addr[IDX_W-1:0]];
      end else begin
        rd_w_s[i] = '0;
      end
    end
  end

  // Input state decode; the unused encoding behaves as INVALID
  always_comb begin
    case (bus.pe_in_state)
      ST_VALID: in_tag_s = ST_VALID;
      ST_FIN:   in_tag_s = ST_FIN;
      default:  in_tag_s = ST_INVALID;
    endcase
  end

  // Stage 1: per-lane products and the tag that travels with them
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_r <= ST_INVALID;
      for (int i = 0; i < ICP_NUM; i++) begin
        prod_r[i] <= '0;
      end
    end else begin
      tag_r <= in_tag_s;
      for (int i = 0; i < ICP_NUM; i++) begin
        prod_r[i] <= PROD_W'(bus.pe_in_a[i*DATA_WID +: DATA_WID]) * PROD_W'(rd_w_s[i]);
      end
    end
  end

  // Cross-lane reduction and the accumulator update candidate
  always_comb begin
    lane_sum_s = '0;
    for (int i = 0; i < ICP_NUM; i++) begin
      lane_sum_s = lane_sum_s + OUT_W'(prod_r[i]);
    end
    acc_sum_s = acc_add(acc_r, lane_sum_s);
  end

  // Stage 2: accumulate, or close the window and publish the result
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= '0;
      out_state_r <= ST_INVALID;
      out_data_r  <= '0;
    end else begin
      case (tag_r)
        ST_VALID: begin
          acc_r       <= acc_sum_s;
          out_state_r <= ST_INVALID;
        end
        ST_FIN: begin
          acc_r       <= '0;
          out_state_r <= ST_FIN;
          out_data_r  <= acc_sum_s;
        end
        default: begin
          out_state_r <= ST_INVALID;
        end
      endcase
    end
  end

  assign bus.pe_out_state = out_state_r;
  assign bus.pe_out_data  = out_data_r;

endmodule

// File: tb/tb_cnn_pe_top.sv
// Scoreboard bench for cnn_pe_top: directed windows from the test plan followed
// by randomized traffic, all checked against a window-level arithmetic model.
module tb_cnn_pe_top;

  localparam int  NL   = 4;
  localparam int  DEP  = 9;
  localparam int  OW   = 21;
  localparam longint MAXV = (longint'(1) << OW) - 1;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  logic   clk;
  logic   reset;
  int     cyc;
  int     checks;
  int     errors;
  exp_t   q[$];
  longint wm [NL][DEP];
  longint acc_m;

  cnn_pe_top_if bus ();

  cnn_pe_top dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint m_add(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef PE_ACC_SAT_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s & MAXV;
`endif
  endfunction

  // One input cycle: model the window arithmetic, then let the edge happen
  task automatic drive(input logic [1:0] st, input logic [31:0] a, input logic [3:0] rd,
                       input logic [7:0] wd, input logic [3:0] wa, input logic [3:0] we);
    longint s;
    exp_t   e;
    bus.pe_in_state = st;
    bus.pe_in_a     = a;
    bus.rdb_addr    = rd;
    bus.wrb_data    = wd;
    bus.wrb_addr    = wa;
    bus.wrb         = we;
    s = 0;
    for (int i = 0; i < NL; i++) begin
      if (int'(rd) < DEP) s += longint'(a[i*8 +: 8]) * wm[i][rd];
    end
    if (st == 2'd1) begin
      acc_m = m_add(acc_m, s);
    end else if (st == 2'd2) begin
      e.val = m_add(acc_m, s);
      e.due = cyc + 2;
      q.push_back(e);
      acc_m = 0;
    end
    for (int i = 0; i < NL; i++) begin
      if (we[i] && int'(wa) < DEP) wm[i][wa] = longint'(wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'd0, $urandom, 4'($urandom_range(0, 15)), 8'($urandom), 4'd0, 4'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      bus.pe_in_state = 2'd0;
      bus.pe_in_a     = $urandom;
      bus.rdb_addr    = 4'($urandom);
      bus.wrb_data    = 8'($urandom);
      bus.wrb_addr    = 4'($urandom);
      bus.wrb         = 4'($urandom);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    for (int i = 0; i < NL; i++) for (int j = 0; j < DEP; j++) wm[i][j] = 0;
    acc_m = 0;
    q.delete();
  endtask

  task automatic load_ramp();
    for (int k = 0; k < DEP; k++) drive(2'd0, $urandom, 4'($urandom), 8'(k + 1), 4'(k), 4'hF);
  endtask

  function automatic logic [31:0] ramp_a(input int k);
    logic [31:0] a;
    for (int i = 0; i < NL; i++) a[i*8 +: 8] = 8'(16 * i + k);
    return a;
  endfunction

  task automatic window_ramp(input bit bubbles);
    for (int k = 0; k < DEP; k++) begin
      drive((k < 8) ? 2'd1 : 2'd2, ramp_a(k), 4'(k), 8'd0, 4'd0, 4'd0);
      if (bubbles && k < 8) begin
        repeat ($urandom_range(1, 2))
          drive($urandom_range(0, 1) ? 2'd0 : 2'd3, $urandom, 4'($urandom), 8'd0, 4'd0, 4'd0);
      end
    end
  endtask

  task automatic check_result(input string nm, input longint exp);
    idle(1);
    chk({nm, "_state"}, 64'(bus.pe_out_state), 64'd2);
    chk({nm, "_data"},  64'(bus.pe_out_data), 64'(exp));
    idle(1);
    chk({nm, "_state_after"}, 64'(bus.pe_out_state), 64'd0);
    chk({nm, "_hold"},  64'(bus.pe_out_data), 64'(exp));
  endtask

  // Monitor: pops the scoreboard whenever the DUT tags a result
  initial begin
    longint hold;
    bit     rs;
    exp_t   e;
    hold = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      @(negedge clk);
      if (rs) begin
        hold = 0;
        chk("reset_state", 64'(bus.pe_out_state), 64'd0);
        chk("reset_data",  64'(bus.pe_out_data), 64'd0);
      end else if (bus.pe_out_state == 2'd2) begin
        if (q.size() == 0) begin
          chk("unexpected_fin", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("fin_data",    64'(bus.pe_out_data), 64'(e.val));
          chk("fin_latency", 64'(cyc), 64'(e.due));
          hold = e.val;
        end
      end else begin
        chk("idle_state", 64'(bus.pe_out_state), 64'd0);
        chk("idle_hold",  64'(bus.pe_out_data), 64'(hold));
        if (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          chk("missing_fin", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    logic [1:0] st;
    int         r;
    checks = 0;
    errors = 0;
    acc_m  = 0;
    reset  = 1'b1;
    do_reset(2);

    load_ramp();
    window_ramp(1'b0);
    check_result("window", 5280);

    window_ramp(1'b1);
    check_result("bubbles", 5280);

    window_ramp(1'b0);
    for (int k = 0; k < DEP; k++) drive((k < 8) ? 2'd1 : 2'd2, 32'h01010101, 4'(k), 8'd0, 4'd0, 4'd0);
    check_result("back2back", 180);

    do_reset(1);
    drive(2'd0, 32'd0, 4'd0, 8'hFF, 4'd0, 4'b0001);
    drive(2'd0, 32'd0, 4'd0, 8'h55, 4'd9, 4'hF);
    drive(2'd2, 32'hFFFFFFFF, 4'd0, 8'd0, 4'd0, 4'd0);
    check_result("lane0_max", 65025);
    for (int r9 = 1; r9 < 16; r9++) drive(2'd2, 32'hFFFFFFFF, 4'(r9), 8'd0, 4'd0, 4'd0);
    check_result("oob_read", 0);

    load_ramp();
    for (int k = 0; k < 4; k++) drive(2'd1, ramp_a(k), 4'(k), 8'd0, 4'd0, 4'd0);
    do_reset(1);
    load_ramp();
    window_ramp(1'b0);
    check_result("post_reset", 5280);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(1);
      end else begin
        r = $urandom_range(0, 9);
        st = (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
        drive(st, $urandom, 4'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
      end
    end
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
